// File: rtl/usb_uart_rx.sv
// usb_uart_rx: 8N1 serial receiver for the USB-serial bridge line.
// A 2-FF synchroniser feeds a centre-sampling receive FSM. Each completed
// byte is delivered through a single-entry holding register with a
// valid/ready handshake. One-cycle pulses report framing errors and overruns.
// Optional build macro USB_UART_RX_PARITY_EN switches the frame to 8E1 and
// adds the parity_err output.
`timescale 1ns/1ps
module usb_uart_rx #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 1000000,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       usb_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef USB_UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_cfg
      $error("usb_uart_rx: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t           state, state_nxt;
  logic             sync_p0, rxs;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             cnt_clr, data_smp, commit, ferr;
`ifdef USB_UART_RX_PARITY_EN
  logic             par_bit, par_smp, perr;
`endif

  // Two-stage synchroniser for the asynchronous serial line (idles high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      sync_p0 <= usb_rx;
      rxs     <= sync_p0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and per-cycle sample/commit strobes
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    data_smp  = 1'b0;
    commit    = 1'b0;
    ferr      = 1'b0;
`ifdef USB_UART_RX_PARITY_EN
    par_smp   = 1'b0;
    perr      = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (!rxs) state_nxt = S_START;
      end
      S_START: begin
        // Half-bit check rejects short glitches on the line
        if (clk_cnt == CNT_HALF) begin
          cnt_clr   = 1'b1;
          state_nxt = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (clk_cnt == CNT_LAST) begin
          cnt_clr  = 1'b1;
          data_smp = 1'b1;
`ifdef USB_UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state_nxt = S_PARITY;
`else
          if (bit_idx == 3'd7) state_nxt = S_STOP;
`endif
        end
      end
`ifdef USB_UART_RX_PARITY_EN
      S_PARITY: begin
        if (clk_cnt == CNT_LAST) begin
          cnt_clr   = 1'b1;
          par_smp   = 1'b1;
          state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (clk_cnt == CNT_LAST) begin
          cnt_clr = 1'b1;
          if (!rxs) begin
            // Framing error wins over any parity result
            ferr      = 1'b1;
            state_nxt = S_BREAK;
          end else begin
            state_nxt = S_IDLE;
`ifdef USB_UART_RX_PARITY_EN
            if (par_bit != ^shift) perr = 1'b1;
            else                   commit = 1'b1;
`else
            commit = 1'b1;
`endif
          end
        end
      end
      S_BREAK: begin
        // Wait for the line to go idle so a held-low line cannot retrigger
        cnt_clr = 1'b1;
        if (rxs) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit-timing counter, bit index and receive shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef USB_UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      clk_cnt <= cnt_clr ? '0 : clk_cnt + 1'b1;
      if (state == S_START)  bit_idx <= '0;
      else if (data_smp)     bit_idx <= bit_idx + 1'b1;
      if (data_smp)          shift[bit_idx] <= rxs;
`ifdef USB_UART_RX_PARITY_EN
      if (par_smp)           par_bit <= rxs;
`endif
    end
  end

  // Holding register, handshake and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef USB_UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= ferr;
      overrun   <= 1'b0;
`ifdef USB_UART_RX_PARITY_EN
      parity_err <= perr;
`endif
      if (commit) begin
        // A byte consumed in the same cycle frees the slot for the new one
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun  <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_usb_uart_rx.sv
// tb_usb_uart_rx: self-checking bench for usb_uart_rx at 100 clocks per bit.
// Frames are driven at the serial level; a negedge monitor collects accepted
// bytes and counts status pulses; each test compares against expectations
// derived from the frame contents it sent.
`timescale 1ns/1ps
module tb_usb_uart_rx;

  localparam int CPB = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       usb_rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef USB_UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
`endif

  always #5 clk = ~clk;

  usb_uart_rx #(.CLK_FREQ(100000000), .BAUD(1000000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .usb_rx    (usb_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef USB_UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] got_q[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         pe_cnt = 0;
  int         stab_err = 0;
  logic       prev_valid = 1'b0;
  logic       prev_acc = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // Monitor: accepted bytes, status pulses, holding-register stability
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overrun)   ov_cnt <= ov_cnt + 1;
`ifdef USB_UART_RX_PARITY_EN
      if (parity_err) pe_cnt <= pe_cnt + 1;
`endif
      if (prev_valid && !prev_acc && rx_valid && rx_data !== prev_data)
        stab_err <= stab_err + 1;
    end
    prev_valid <= rx_valid;
    prev_acc   <= rx_valid && rx_ready;
    prev_data  <= rx_data;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    usb_rx = b;
    tick(CPB);
  endtask

  // Start bit, 8 data bits LSB first, optional even parity, stop bit.
  // The line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef USB_UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop_b);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; usb_rx = 1'b1; rx_ready = 1'b0;
    #3;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rx_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
`ifdef USB_UART_RX_PARITY_EN
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err got=%b want=0", parity_err); end
`endif
    tick(3);
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_single();
    int g0 = got_q.size(); int f0 = fe_cnt; int o0 = ov_cnt;
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    tick(CPB);
    total++; if (got_q.size() - g0 != 1) begin bad++; $display("FAIL single_count got=%0d want=1", got_q.size() - g0); end
    if (got_q.size() > g0) begin
      total++; if (got_q[g0] !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", got_q[g0]); end
    end
    total++; if (fe_cnt - f0 != 0) begin bad++; $display("FAIL single_frame_err got=%0d want=0", fe_cnt - f0); end
    total++; if (ov_cnt - o0 != 0) begin bad++; $display("FAIL single_overrun got=%0d want=0", ov_cnt - o0); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL single_valid_cleared got=%b want=0", rx_valid); end
  endtask

  task automatic test_overrun();
    int g0 = got_q.size(); int o0 = ov_cnt;
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    tick(CPB / 2);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid_held got=%b want=1", rx_valid); end
    total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL ovr_data_kept got=%h want=3c", rx_data); end
    total++; if (ov_cnt - o0 != 1) begin bad++; $display("FAIL ovr_pulses got=%0d want=1", ov_cnt - o0); end
    total++; if (got_q.size() != g0) begin bad++; $display("FAIL ovr_no_accept got=%0d want=0", got_q.size() - g0); end
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(2);
    total++; if (got_q.size() - g0 != 1) begin bad++; $display("FAIL ovr_consume_count got=%0d want=1", got_q.size() - g0); end
    if (got_q.size() > g0) begin
      total++; if (got_q[g0] !== 8'h3C) begin bad++; $display("FAIL ovr_consume_data got=%h want=3c", got_q[g0]); end
    end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_valid_cleared got=%b want=0", rx_valid); end
  endtask

  task automatic test_frame_err();
    int g0 = got_q.size(); int f0 = fe_cnt;
    rx_ready = 1'b1;
    send_frame(8'h55, 1'b0);
    tick(20 * CPB);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_held got=%b want=1", busy); end
    total++; if (fe_cnt - f0 != 1) begin bad++; $display("FAIL ferr_pulses got=%0d want=1", fe_cnt - f0); end
    total++; if (got_q.size() != g0) begin bad++; $display("FAIL ferr_no_byte got=%0d want=0", got_q.size() - g0); end
    usb_rx = 1'b1;
    tick(10);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy_release got=%b want=0", busy); end
    tick(CPB);
    send_frame(8'h01, 1'b1);
    tick(CPB);
    total++; if (got_q.size() - g0 != 1) begin bad++; $display("FAIL ferr_next_count got=%0d want=1", got_q.size() - g0); end
    if (got_q.size() > g0) begin
      total++; if (got_q[g0] !== 8'h01) begin bad++; $display("FAIL ferr_next_data got=%h want=01", got_q[g0]); end
    end
    total++; if (fe_cnt - f0 != 1) begin bad++; $display("FAIL ferr_no_extra got=%0d want=1", fe_cnt - f0); end
  endtask

  task automatic test_glitch();
    int g0 = got_q.size(); int f0 = fe_cnt; int o0 = ov_cnt;
    usb_rx = 1'b0;
    tick(30);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_start got=%b want=1", busy); end
    usb_rx = 1'b1;
    tick(40);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b want=0", busy); end
    tick(CPB);
    total++; if (got_q.size() != g0 || rx_valid !== 1'b0) begin bad++; $display("FAIL glitch_no_byte got=%0d want=0", got_q.size() - g0); end
    total++; if (fe_cnt != f0 || ov_cnt != o0) begin bad++; $display("FAIL glitch_flags got=%0d want=0", (fe_cnt - f0) + (ov_cnt - o0)); end
  endtask

  task automatic test_reset_mid();
    int g0; int f0; int o0;
    rx_ready = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    usb_rx = 1'b1;
    tick(CPB / 2);
    rst_n = 1'b0;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h want=00", rx_data); end
    total++; if (rx_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL rstmid_flags got=%b%b%b want=000", rx_valid, frame_err, overrun); end
    tick(5);
    rst_n = 1'b1;
    tick(CPB);
    g0 = got_q.size(); f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'h81, 1'b1);
    tick(CPB);
    total++; if (got_q.size() - g0 != 1) begin bad++; $display("FAIL rstmid_count got=%0d want=1", got_q.size() - g0); end
    if (got_q.size() > g0) begin
      total++; if (got_q[g0] !== 8'h81) begin bad++; $display("FAIL rstmid_data_after got=%h want=81", got_q[g0]); end
    end
    total++; if (fe_cnt != f0 || ov_cnt != o0) begin bad++; $display("FAIL rstmid_err got=%0d want=0", (fe_cnt - f0) + (ov_cnt - o0)); end
  endtask

  // Random bytes, random consumer style, random gaps and bad stop bits
  task automatic test_random();
    logic [7:0] exp_q[$];
    int exp_fe = 0;
    int g0 = got_q.size(); int f0 = fe_cnt; int o0 = ov_cnt; int p0 = pe_cnt;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic       bad_stop;
      logic       hold_ready;
      d          = 8'($urandom);
      bad_stop   = ($urandom_range(0, 4) == 0);
      hold_ready = 1'($urandom_range(0, 1));
      rx_ready   = hold_ready;
      send_frame(d, !bad_stop);
      if (bad_stop) begin
        exp_fe++;
        usb_rx = 1'b1;
        tick(CPB / 4);
      end else begin
        exp_q.push_back(d);
      end
      if (!hold_ready) begin
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
      tick($urandom_range(0, 2) * CPB);
    end
    tick(CPB);
    total++; if (got_q.size() - g0 != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", got_q.size() - g0, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      total++; if (got_q[g0 + i] !== exp_q[i]) begin bad++; $display("FAIL rand_data[%0d] got=%h want=%h", i, got_q[g0 + i], exp_q[i]); end
    end
    total++; if (fe_cnt - f0 != exp_fe) begin bad++; $display("FAIL rand_frame_err got=%0d want=%0d", fe_cnt - f0, exp_fe); end
    total++; if (ov_cnt != o0) begin bad++; $display("FAIL rand_overrun got=%0d want=0", ov_cnt - o0); end
    total++; if (pe_cnt != p0) begin bad++; $display("FAIL rand_parity got=%0d want=0", pe_cnt - p0); end
  endtask

`ifdef USB_UART_RX_PARITY_EN
  task automatic test_parity();
    int g0 = got_q.size(); int p0 = pe_cnt;
    rx_ready = 1'b1;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    tick(CPB);
    total++; if (pe_cnt - p0 != 1) begin bad++; $display("FAIL par_err_pulse got=%0d want=1", pe_cnt - p0); end
    total++; if (got_q.size() != g0) begin bad++; $display("FAIL par_err_no_byte got=%0d want=0", got_q.size() - g0); end
    send_frame(8'h07, 1'b1);
    tick(CPB);
    total++; if (got_q.size() - g0 != 1) begin bad++; $display("FAIL par_ok_count got=%0d want=1", got_q.size() - g0); end
    if (got_q.size() > g0) begin
      total++; if (got_q[g0] !== 8'h07) begin bad++; $display("FAIL par_ok_data got=%h want=07", got_q[g0]); end
    end
    total++; if (pe_cnt - p0 != 1) begin bad++; $display("FAIL par_ok_no_err got=%0d want=1", pe_cnt - p0); end
  endtask
`endif

  task automatic test_stability();
    total++; if (stab_err != 0) begin bad++; $display("FAIL data_stability got=%0d want=0", stab_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_random();
`ifdef USB_UART_RX_PARITY_EN
    test_parity();
`endif
    test_stability();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_uart_rx.md
Name: usb_uart_rx

Overview:
- Receives serial bytes on the board's `usb_rx` line from the USB-serial bridge and delivers them to the downstream core logic.
- Downstream consumers include the LED/command logic driving `led[7:0]`.
- Frame format: 8N1, LSB first, 2-FF input synchroniser, centre-of-bit sampling.
- Output is a single-entry holding register with a valid/ready handshake, plus error and overrun flags.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz (10 ns period).
- BAUD, 1000000, serial bit rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer divide), clocks per bit. Must be >= 4; elaboration error otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- usb_rx  input  1  asynchronous serial input; idle high.
- rx_data  output  8  received byte (holding register).
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts rx_data this cycle when rx_valid=1.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while the holding register was full; new byte dropped.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Both synchroniser FFs = 1, FSM = IDLE, counters = 0.
  - rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0.
- Synchroniser: usb_rx passes through 2 FFs; all logic uses the second-stage value (rxs). Input latency is 2 cycles.
- Bit counter: clk_cnt has width clog2(CLKS_PER_BIT) and counts 0..CLKS_PER_BIT-1; bit_idx counts 0..7.
- IDLE:
  - rxs==0 -> START, clk_cnt=0.
- START:
  - When clk_cnt==CLKS_PER_BIT/2-1, sample rxs.
  - rxs==1 -> glitch; return to IDLE with no flags.
  - rxs==0 -> DATA, clk_cnt=0, bit_idx=0.
- DATA:
  - At clk_cnt==CLKS_PER_BIT-1, sample rxs into shift[bit_idx], LSB first.
  - After bit_idx==7 -> STOP.
- STOP:
  - At clk_cnt==CLKS_PER_BIT-1, sample rxs.
  - rxs==1 -> commit byte (see delivery rules) and go to IDLE.
  - rxs==0 -> frame_err pulses 1 cycle, byte discarded, go to BREAK.
- BREAK:
  - Stay until rxs==1, then go to IDLE. This prevents a held-low line from retriggering.
- Delivery, evaluated on the commit cycle; outputs update on the next edge:
  - rx_valid==0 -> rx_data=shift, rx_valid=1.
  - rx_valid==1 && rx_ready==1 -> rx_data=shift, rx_valid stays 1, no overrun.
  - rx_valid==1 && rx_ready==0 -> overrun pulses 1 cycle; rx_data and rx_valid unchanged.
- Handshake:
  - With no commit, rx_valid && rx_ready clears rx_valid on the next edge.
  - rx_data is stable while rx_valid=1.
  - rx_ready while rx_valid=0 has no effect.
- Latency: rx_valid rises 1 cycle after the stop-bit centre sample, about 9.5 bit times plus 3 cycles after the usb_rx falling edge.
- Back-to-back frames: a start bit immediately after the stop-bit sample is detected. IDLE is re-entered at the stop-bit centre, leaving half a bit of slack.
- Reset mid-frame: all state is cleared immediately; any partial byte is lost and no flags are raised.
- busy = (state != IDLE).

Optional Feature:
- Macro: USB_UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1: a PARITY state is inserted between DATA and STOP and samples 1 bit.
  - Adds output port parity_err (1 bit, reset 0).
  - In STOP with stop bit high, if the received parity != ^shift (even parity), parity_err pulses 1 cycle and the byte is discarded (no rx_valid, no overrun).
  - frame_err takes priority; parity_err is not raised on a framing error.
- Undefined: 8N1 only; no PARITY state and no parity_err port.

Test Plan:
- Send 8'hA5 at 1 Mbaud (100 clks/bit) with rx_ready=1 -> rx_valid pulses 1 cycle with rx_data=8'hA5; frame_err=0, overrun=0.
- Hold rx_ready=0 and send 8'h3C then 8'hC3 back to back -> rx_data=8'h3C with rx_valid held; overrun pulses once at the second stop bit; rx_data stays 8'h3C.
- Send 8'h55 with the stop bit driven low, then hold the line low for 20 bit times -> frame_err pulses once, no rx_valid, busy stays 1 until usb_rx returns high; a following 8'h01 is then received correctly.
- Drive a 30-cycle low glitch on usb_rx -> no rx_valid, no flags, FSM back in IDLE (busy=0) after the half-bit check.
- Assert rst_n=0 during bit 4 of 8'hFF, release it, then send 8'h81 -> outputs at reset values during reset; next rx_data=8'h81 with no error flags.
- With USB_UART_RX_PARITY_EN defined: send 8'h07 with parity bit 0 (wrong) -> parity_err pulses and no rx_valid; resend with parity 1 -> rx_data=8'h07, rx_valid=1.
